// File: rtl/ws2812_serializer.sv
// WS2812 serializer: a one-word holding register feeds a bit shifter that drives
// WS2812 high/low pulse timing on a registered led output, with an optional latch gap.
module ws2812_serializer #(
  parameter int T0H_CYC   = 8,
  parameter int T1H_CYC   = 16,
  parameter int BIT_CYC   = 25,
  parameter int RESET_CYC = 6000
) (
  input  logic        clk20,
  input  logic        reset,
  input  logic [23:0] data_in,
  input  logic        valid,
  input  logic        latch,
  output logic        ready,
  output logic        led,
  output logic        busy
);

  localparam int PW = $clog2(BIT_CYC);
  localparam int LW = $clog2(RESET_CYC + 1);

  localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYC - 1);
  localparam logic [PW-1:0] PH_T0H  = PW'(T0H_CYC);
  localparam logic [PW-1:0] PH_T1H  = PW'(T1H_CYC);
  localparam logic [LW-1:0] LC_LAST = LW'(RESET_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_LATCH
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   hold_dat_q, hold_dat_d;
  logic          hold_lat_q, hold_lat_d;
  logic          hold_full_q, hold_full_d;
  logic [23:0]   shreg_q, shreg_d;
  logic          word_lat_q, word_lat_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [4:0]    bit_idx_q, bit_idx_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          led_q, led_d;
  logic          accept;
  logic          load;

  // Accept needs an empty holding register and load needs a full one, so they never collide.
  assign accept = valid && !hold_full_q;

  always_comb begin
    state_d     = state_q;
    hold_dat_d  = hold_dat_q;
    hold_lat_d  = hold_lat_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    word_lat_d  = word_lat_q;
    phase_d     = phase_q;
    bit_idx_d   = bit_idx_q;
    lcnt_d      = lcnt_q;
    load        = 1'b0;
    led_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      S_SEND: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (bit_idx_q == 5'd0) begin
            if (word_lat_q) begin
              state_d = S_LATCH;
              lcnt_d  = '0;
            end else if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q - 5'd1;
            shreg_d   = {shreg_q[22:0], 1'b0};
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (lcnt_q == LC_LAST) begin
          lcnt_d = '0;
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      state_d     = S_SEND;
      shreg_d     = hold_dat_q;
      word_lat_d  = hold_lat_q;
      bit_idx_d   = 5'd23;
      phase_d     = '0;
      hold_full_d = 1'b0;
    end

    if (accept) begin
      hold_dat_d  = data_in;
      hold_lat_d  = latch;
      hold_full_d = 1'b1;
    end

    // led is computed from next-state values so the pulse lines up with the registered phase.
    led_d = (state_d == S_SEND) && (phase_d < (shreg_d[23] ? PH_T1H : PH_T0H));
  end

  always_ff @(posedge clk20) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_dat_q  <= '0;
      hold_lat_q  <= 1'b0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      word_lat_q  <= 1'b0;
      phase_q     <= '0;
      bit_idx_q   <= '0;
      lcnt_q      <= '0;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_dat_q  <= hold_dat_d;
      hold_lat_q  <= hold_lat_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      word_lat_q  <= word_lat_d;
      phase_q     <= phase_d;
      bit_idx_q   <= bit_idx_d;
      lcnt_q      <= lcnt_d;
      led_q       <= led_d;
    end
  end

  assign ready = ~hold_full_q;
  assign busy  = (state_q != S_IDLE) || hold_full_q;
  assign led   = led_q;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed bench for ws2812_serializer: words are pushed to a pulse scoreboard as
// they are offered, and a negedge monitor decodes led pulses against it.
module tb_ws2812_serializer;

  localparam int T0H  = 2;
  localparam int T1H  = 5;
  localparam int BIT  = 8;
  localparam int RST  = 100;
  localparam int WORD = 24 * BIT;
  localparam int TMO  = 2 * WORD + RST + 50;

  typedef struct {
    int w;
    int gap;
  } pulse_t;

  logic        clk20 = 1'b0;
  logic        reset;
  logic [23:0] data_in;
  logic        valid;
  logic        latch;
  logic        ready;
  logic        led;
  logic        busy;

  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  pulse_t sb_q[$];
  bit     mon_en = 1'b0;
  int     hi_cnt = 0;
  int     rise_cyc = 0;
  int     prev_rise = 0;
  logic   led_prev = 1'b0;

  int          t;
  int          c0;
  int          edges;
  logic [23:0] w;

  ws2812_serializer #(
    .T0H_CYC  (T0H),
    .T1H_CYC  (T1H),
    .BIT_CYC  (BIT),
    .RESET_CYC(RST)
  ) dut (
    .clk20  (clk20),
    .reset  (reset),
    .data_in(data_in),
    .valid  (valid),
    .latch  (latch),
    .ready  (ready),
    .led    (led),
    .busy   (busy)
  );

  always #25 clk20 = ~clk20;

  always @(posedge clk20) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse decoder: every completed high pulse is checked against the scoreboard head.
  always @(negedge clk20) begin
    pulse_t e;
    if (!mon_en) begin
      hi_cnt   = 0;
      led_prev = 1'b0;
    end else begin
      if (led === 1'b1) begin
        if (led_prev !== 1'b1) begin
          prev_rise = rise_cyc;
          rise_cyc  = cyc;
        end
        hi_cnt++;
      end else if (hi_cnt != 0) begin
        chk("pulse_expected", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("pulse_width", hi_cnt, e.w);
          if (e.gap != 0) chk("rise_to_rise", rise_cyc - prev_rise, e.gap);
        end
        hi_cnt = 0;
      end
      led_prev = led;
    end
  end

  task automatic push_word(input logic [23:0] d, input int first_gap);
    pulse_t e;
    for (int i = 23; i >= 0; i--) begin
      e.w   = d[i] ? T1H : T0H;
      e.gap = (i == 23) ? first_gap : BIT;
      sb_q.push_back(e);
    end
  endtask

  task automatic send(input logic [23:0] d, input logic l, input int first_gap);
    int tt = 0;
    while (ready !== 1'b1 && tt < TMO) begin
      @(negedge clk20);
      tt++;
    end
    chk("ready_before_send", ready, 1);
    data_in = d;
    latch   = l;
    valid   = 1'b1;
    push_word(d, first_gap);
    @(negedge clk20);
    valid   = 1'b0;
    latch   = 1'b0;
    data_in = 24'($urandom);
  endtask

  task automatic wait_ready();
    int tt = 0;
    while (ready !== 1'b1 && tt < TMO) begin
      @(negedge clk20);
      tt++;
    end
    chk("wait_ready", ready, 1);
  endtask

  task automatic wait_idle(input string tag);
    int tt = 0;
    while (busy !== 1'b0 && tt < TMO) begin
      @(negedge clk20);
      tt++;
    end
    chk({tag, "_idle"}, busy, 0);
    repeat (2) @(negedge clk20);
    chk({tag, "_sb_empty"}, sb_q.size(), 0);
    chk({tag, "_led_low"}, led, 0);
  endtask

  initial begin
    #(90000 * 50);
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    valid   = 1'b0;
    latch   = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk20);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_led", led, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk20);

    // Single word from IDLE: one-cycle ready dip and exact word length.
    send(24'h800000, 1'b0, 0);
    chk("t1_ready_low", ready, 0);
    chk("t1_busy_held", busy, 1);
    chk("t1_led_before_load", led, 0);
    @(negedge clk20);
    chk("t1_ready_back", ready, 1);
    chk("t1_led_first_high", led, 1);
    repeat (WORD - 1) @(negedge clk20);
    chk("t1_busy_last_cycle", busy, 1);
    @(negedge clk20);
    chk("t1_busy_done", busy, 0);
    wait_idle("t1");

    // Back-to-back words with no gap; ready returns exactly one word later.
    send(24'hFFFFFF, 1'b0, 0);
    @(negedge clk20);
    chk("t2_ready_after_load", ready, 1);
    c0 = cyc;
    send(24'h000000, 1'b0, BIT);
    chk("t2_ready_queued", ready, 0);
    wait_ready();
    chk("t2_second_load_time", cyc - c0, WORD);
    wait_idle("t2");

    // Latch word with a word queued before the latch gap.
    send(24'h00AA55, 1'b1, 0);
    @(negedge clk20);
    send(24'h123456, 1'b0, BIT + RST);
    wait_idle("t3");

    // Word queued during LATCH, then a latch word that drains to IDLE.
    send(24'hC0FFEE, 1'b1, 0);
    @(negedge clk20);
    repeat (WORD + 10) @(negedge clk20);
    chk("t4_latch_led", led, 0);
    chk("t4_latch_busy", busy, 1);
    chk("t4_latch_ready", ready, 1);
    send(24'h5A5A5A, 1'b1, BIT + RST);
    wait_ready();
    repeat (WORD + RST - 1) @(negedge clk20);
    chk("t4_latch_busy_last", busy, 1);
    @(negedge clk20);
    chk("t4_latch_idle", busy, 0);
    wait_idle("t4");

    // valid held while not ready with changing data: only the accepted word is sent.
    send(24'hA5A5A5, 1'b0, 0);
    @(negedge clk20);
    send(24'h3C3C3C, 1'b0, BIT);
    valid = 1'b1;
    t = 0;
    while (t < TMO) begin
      data_in = 24'($urandom);
      if (ready === 1'b1) break;
      @(negedge clk20);
      t++;
    end
    chk("t5_ready_seen", ready, 1);
    push_word(data_in, BIT);
    @(negedge clk20);
    valid   = 1'b0;
    data_in = 24'($urandom);
    wait_idle("t5");

    // Reset mid-word with a queued word.
    send(24'hF0F0F0, 1'b0, 0);
    @(negedge clk20);
    send(24'h0F0F0F, 1'b0, BIT);
    repeat (11 * BIT + 3) @(negedge clk20);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk20);
    chk("t6_led", led, 0);
    chk("t6_ready", ready, 1);
    chk("t6_busy", busy, 0);
    reset = 1'b0;
    sb_q.delete();
    edges = 0;
    repeat (2 * WORD) begin
      @(negedge clk20);
      if (led !== 1'b0) edges++;
    end
    chk("t6_led_silent", edges, 0);
    chk("t6_busy_after", busy, 0);

    // Reset mid-latch with a queued word.
    mon_en = 1'b1;
    send(24'h000001, 1'b1, 0);
    repeat (WORD + 20) @(negedge clk20);
    send(24'hFFFFFF, 1'b0, BIT + RST);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk20);
    chk("t6b_led", led, 0);
    chk("t6b_ready", ready, 1);
    chk("t6b_busy", busy, 0);
    reset = 1'b0;
    sb_q.delete();
    edges = 0;
    repeat (RST + WORD) begin
      @(negedge clk20);
      if (led !== 1'b0) edges++;
    end
    chk("t6b_led_silent", edges, 0);
    mon_en = 1'b1;

    // Controller-style stream of 280 words, last one latched.
    for (int k = 0; k < 280; k++) begin
      w = 24'($urandom);
      send(w, (k == 279), (k == 0) ? 0 : BIT);
    end
    wait_idle("t7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ws2812_serializer.md
WS2812_SERIALIZER -- requirements
Module: ws2812_serializer

Interface
REQ-001 Parameter T0H_CYC, default 8: clk20 cycles that led is high for a 0 bit (400 ns at 20 MHz).
REQ-002 Parameter T1H_CYC, default 16: clk20 cycles that led is high for a 1 bit (800 ns).
REQ-003 Parameter BIT_CYC, default 25: total clk20 cycles per bit (1.25 us).
REQ-004 Parameter RESET_CYC, default 6000: clk20 cycles that led is held low for a latch (300 us).
REQ-005 Port clk20, input, 1: the single clock (20 MHz); all logic on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port data_in, input, 24: one LED word, GRB order as composed upstream; bit 23 is transmitted first.
REQ-008 Port valid, input, 1: data_in and latch are valid this cycle.
REQ-009 Port latch, input, 1: after this word, send a latch (reset) gap.
REQ-010 Port ready, output, 1: the holding register is empty and a word can be accepted.
REQ-011 Port led, output, 1: registered serial output to the LED strip data line.
REQ-012 Port busy, output, 1: high while the shifter is not in IDLE or the holding register is full.

Function
REQ-013 The block SHALL contain a one-word holding register (24 data bits plus the latch flag) and a separate shifter.
REQ-014 ready SHALL equal NOT hold_full, decoded directly from the register bit.
REQ-015 A word is accepted on the edge where valid and ready are both high: data_in and latch load into the holding register and hold_full is set.
REQ-016 valid while ready is low SHALL be ignored; the holding contents are unchanged.
REQ-017 Accept and drain cannot coincide: accept requires hold empty and drain requires hold full. The design SHALL NOT rely on any other arbitration.
REQ-018 Shifter states SHALL be IDLE, SEND and LATCH.
REQ-019 IDLE with hold_full: on the next edge the shifter loads the word, clears hold_full, sets bit_idx=23 and phase=0, and enters SEND.
REQ-020 Accept-to-output latency from IDLE SHALL be exactly one cycle: led first rises on the edge after acceptance, and ready is low for exactly one cycle.
REQ-021 In SEND, led SHALL be 1 while phase < (current bit ? T1H_CYC : T0H_CYC), and 0 otherwise.
REQ-022 phase SHALL count 0..BIT_CYC-1 and then wrap to 0, decrementing bit_idx; after bit 0 completes, the word is done.
REQ-023 Word done with latch flag = 0 and hold_full = 1: the next word SHALL load on the same edge, with no extra low cycles between words.
REQ-024 Word done with latch flag = 0 and hold_full = 0: the shifter SHALL go to IDLE with led = 0.
REQ-025 Word done with latch flag = 1: the shifter SHALL enter LATCH and hold led = 0 for exactly RESET_CYC cycles, then go to IDLE, or load a held word directly on the next edge.
REQ-026 During LATCH, ready SHALL still follow REQ-014, so one word may be queued.
REQ-027 Counter widths: phase is clog2(BIT_CYC) bits, bit_idx is 5 bits, and the latch counter is clog2(RESET_CYC+1) bits. No counter SHALL wrap except phase at BIT_CYC-1.
REQ-028 led SHALL be registered, with no combinational path from inputs to led.

Reset
REQ-029 On reset: shifter goes to IDLE, hold_full=0, phase=0, bit_idx=0, latch counter=0, led=0. Consequently ready=1 and busy=0 during and after reset.
REQ-030 Reset asserted mid-word or mid-latch SHALL abort immediately: led is 0 on the next edge and the queued word is discarded.

Verification
REQ-031 Single word 0x800000, latch=0, from IDLE -> ready low for 1 cycle; led high 16 cycles then low 9; then 23 bits of high 8 / low 17; then IDLE with busy=0 (600 cycles total).
REQ-032 Words 0xFFFFFF then 0x000000 back-to-back, the second queued during the first -> 48 contiguous bit periods (1200 cycles) with no gap; ready rises within 1 cycle after each load.
REQ-033 Word 0x00AA55 with latch=1, followed by a queued word -> after bit 0, led low for exactly 6000 cycles; the queued word's first high begins on the next edge.
REQ-034 valid held high while ready=0 with a changing data_in -> only the word present at the accept edge is transmitted.
REQ-035 Reset pulsed at bit 12 of a word with a queued word present -> next cycle led=0, ready=1, busy=0; no further edges on led.
REQ-036 Controller-style loop of 280 words, the last with latch=1 -> the led pulse count and the high widths decode to the sent data bit-exactly.
